clb_cfg_loader: RTL
===================

Name: clb_cfg_loader

Overview:
- Configuration loader that sits directly upstream of the CLB array.
- Receives the serial configuration bitstream, hunts for the preamble, reads a frame count, then deserialises one CFG_W-bit frame per CLB.
- Each completed frame is presented as a parallel word, with its address and a one-cycle write strobe, to the per-CLB configuration registers: the mux selects, the 16-bit LUT, comboption, the o2m selects, the DQ muxes and floporlatch.

Parameters:
- CFG_W, 37, bits per CLB frame. Field map is fixed in the package.
- NUM_CLB, 64, number of CLBs addressable. A frame count above this is an error.
- ADDR_W, 6, width of CFG_ADDR. Must satisfy 2**ADDR_W >= NUM_CLB.
- LEN_W, 8, width of the frame-count field in the bitstream.

Ports:
- K  input  1  clock. All logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  1  serial configuration bit. Sampled only when DIN_VALID=1.
- DIN_VALID  input  1  DIN qualifier. Bits on cycles where it is low are ignored and no state advances.
- CFG_DATA  output  CFG_W  frame word. The first-received bit lands in CFG_DATA[CFG_W-1].
- CFG_ADDR  output  ADDR_W  target CLB index, 0-based, incrementing.
- CFG_WE  output  1  one-cycle write strobe. CFG_DATA and CFG_ADDR are valid while it is high.
- BUSY  output  1  high in LENGTH, FRAME and PAR states.
- DONE  output  1  sticky; cleared only by RST.
- ERR  output  1  sticky; cleared only by RST.

Behaviour:
- Reset values:
  - CFG_DATA=0, CFG_ADDR=0, CFG_WE=0, BUSY=0, DONE=0, ERR=0.
  - State = HUNT, preamble history = 4'b1111.
  - RST mid-load aborts immediately. No further CFG_WE is issued, and CLB contents already written are left untouched.
- States: HUNT, LENGTH, FRAME, PAR (present only with the macro), DONE_S, ERR_S.
- HUNT:
  - Each valid bit shifts into a 4-bit history register, LSB-in.
  - When history equals 4'b0010 after the shift, go to LENGTH on the next cycle.
  - Leading 1s are dummy bits.
- LENGTH:
  - Shift LEN_W valid bits, MSB first, into the count register.
  - On the last bit:
    - count==0: go to DONE_S.
    - count>NUM_CLB: go to ERR_S.
    - otherwise: go to FRAME with the bit counter at 0.
- FRAME:
  - Shift CFG_W valid bits, MSB first.
  - After the last bit, go to PAR if the macro is defined; otherwise commit the frame.
- Commit:
  - On the cycle after the final accepted bit: CFG_WE=1 for exactly one cycle, CFG_DATA=shifted word, CFG_ADDR=frame index.
  - The frame index then increments.
  - If index+1==count, go to DONE_S; else return to FRAME.
  - A valid bit arriving on the commit cycle is accepted as bit 0 of the next frame. There is no dead cycle.
- DONE_S: DONE=1, BUSY=0. All further DIN is ignored.
- ERR_S: ERR=1, BUSY=0. All further DIN is ignored. DONE is never set.
- CFG_DATA and CFG_ADDR hold their last committed values between strobes.
- Simultaneous events: RST has priority over everything. DIN_VALID=0 freezes all counters.

Optional Feature:
- Macro: CLB_CFG_PARITY_EN.
- Defined:
  - Each frame is followed by one extra bit making even parity over the CFG_W data bits plus that bit.
  - State PAR accepts this bit.
  - On match, commit as above.
  - On mismatch, go to ERR_S. No CFG_WE is issued for that frame.
- Undefined:
  - No PAR state and no trailing bit.
  - ERR arises only from count>NUM_CLB.

Decomposition:
- Package clb_cfg_pkg holds:
  - CFG_W=37, PREAMBLE=4'b0010, state enum.
  - Field bit positions:
    - [36:35] mux2select, [34:33] mux3select, [32:31] mux4select, [30:29] mux5select, [28:27] mux6select.
    - [26:11] mem, [10:9] comboption.
    - [8] o2m1_0, [7] o2m2_0, [6] o2m3_0, [5] o2m1_1, [4] o2m2_1, [3] o2m3_1.
    - [2] DQmux1, [1] DQmux2, [0] floporlatch.
- One sub-module: clb_cfg_shift, a generic width-parameterised MSB-first shift register with a bit counter and a "last bit" flag. It is instantiated for both the LENGTH and FRAME phases.

Test Plan:
- Nominal load:
  - Stimulus: stream 1111 0010, count 8'd2, frame 37'h0_0C00_0B00, frame 37'h1F_FFFF_FFFF, continuous DIN_VALID.
  - Response: two CFG_WE pulses, ADDR 0 then 1, with the matching data. DONE=1 one cycle after the second strobe.
- Zero count:
  - Stimulus: preamble then count 8'd0.
  - Response: DONE=1. CFG_WE never asserts. BUSY low afterwards.
- Over-length:
  - Stimulus: count 8'd65 with NUM_CLB=64.
  - Response: ERR=1 after the 8th count bit. No CFG_WE. DONE stays 0.
- Gapped valid:
  - Stimulus: nominal stream with DIN_VALID toggling 1/0 every cycle.
  - Response: identical CFG_DATA/CFG_ADDR sequence, with strobes spaced per the valid bits.
- Reset mid-frame:
  - Stimulus: RST high for 1 cycle at frame bit 20 of frame 1, then a fresh stream with count 1.
  - Response: outputs at reset values, then one strobe at ADDR 0.
- Parity (CLB_CFG_PARITY_EN):
  - Stimulus: frame 37'h1 followed by parity bit 0.
  - Response: ERR=1 and no strobe. With parity bit 1, a normal commit.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
// Shared constants, state encoding and CLB frame field map for the configuration loader.
// CLB_CFG_PARITY_EN adds the PAR state (a trailing even-parity bit after each frame).
package clb_cfg_pkg;

    localparam int          CFG_W    = 37;
    localparam logic [3:0]  PREAMBLE = 4'b0010;
    // Only three past bits are stored; the fourth history bit is the live DIN.
    localparam logic [2:0]  HIST_RST = 3'b111;

    localparam logic [2:0] HUNT   = 3'd0;
    localparam logic [2:0] LENGTH = 3'd1;
    localparam logic [2:0] FRAME  = 3'd2;
`ifdef CLB_CFG_PARITY_EN
    localparam logic [2:0] PAR    = 3'd3;
`endif
    localparam logic [2:0] DONE_S = 3'd4;
    localparam logic [2:0] ERR_S  = 3'd5;

    typedef struct packed {
        logic [1:0]  mux2select;
        logic [1:0]  mux3select;
        logic [1:0]  mux4select;
        logic [1:0]  mux5select;
        logic [1:0]  mux6select;
        logic [15:0] mem;
        logic [1:0]  comboption;
        logic        o2m1_0;
        logic        o2m2_0;
        logic        o2m3_0;
        logic        o2m1_1;
        logic        o2m2_1;
        logic        o2m3_1;
        logic        dqmux1;
        logic        dqmux2;
        logic        floporlatch;
    } clb_cfg_t;

    function automatic logic even_parity_ok(input logic [CFG_W-1:0] data, input logic pbit);
        return ~(^{data, pbit});
    endfunction

endpackage

// File: rtl/clb_cfg_loader_if.sv
// Bitstream input and CLB configuration-write port bundle for the loader.
// master drives the serial stream; slave is the loader.
interface clb_cfg_loader_if #(
    parameter int CFG_W  = clb_cfg_pkg::CFG_W,
    parameter int ADDR_W = 6
);
    logic              DIN;
    logic              DIN_VALID;
    logic [CFG_W-1:0]  CFG_DATA;
    logic [ADDR_W-1:0] CFG_ADDR;
    logic              CFG_WE;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    modport master (
        output DIN, DIN_VALID,
        input  CFG_DATA, CFG_ADDR, CFG_WE, BUSY, DONE, ERR
    );

    modport slave (
        input  DIN, DIN_VALID,
        output CFG_DATA, CFG_ADDR, CFG_WE, BUSY, DONE, ERR
    );
endinterface

// File: rtl/clb_cfg_shift.sv
// MSB-first deserialiser with a bit counter; word already includes the bit on din,
// so the caller can act on the complete value in the same cycle that last is high.
module clb_cfg_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] word,
    output logic         last
);
    localparam int CNT_W = $clog2(W);

    logic [W-2:0]     data_r;
    logic [CNT_W-1:0] cnt_r;

    assign word = {data_r, din};
    assign last = (cnt_r == CNT_W'(W - 1));

    // Shift one accepted bit per enabled cycle; the counter wraps after the last bit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data_r <= {(W-1){1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (en) begin
            data_r <= word[W-2:0];
            cnt_r  <= last ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end
    end
endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: preamble hunt, frame count, per-CLB frame write strobes.
// Define CLB_CFG_PARITY_EN to require a trailing even-parity bit after every frame.
import clb_cfg_pkg::*;

module clb_cfg_loader #(
    parameter int NUM_CLB = 64,
    parameter int ADDR_W  = 6,
    parameter int LEN_W   = 8
) (
    input  logic               K,
    input  logic               RST,
    clb_cfg_loader_if.slave    bus
);
    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [2:0]        hist_r;
    logic [LEN_W-1:0]  count_r;
    logic [LEN_W-1:0]  idx_r;
    logic [CFG_W-1:0]  cfg_data_r;
    logic [ADDR_W-1:0] cfg_addr_r;
    logic              cfg_we_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              clr_s;
    logic              len_en_s;
    logic              len_last_s;
    logic [LEN_W-1:0]  len_word_s;
    logic              frm_en_s;
    logic              frm_last_s;
    logic [CFG_W-1:0]  frm_word_s;
    logic              commit_s;
    logic [CFG_W-1:0]  commit_word_s;
    logic              last_frame_s;
    logic              busy_nx_s;
`ifdef CLB_CFG_PARITY_EN
    logic [CFG_W-1:0]  hold_r;
`endif

    assign clr_s        = (state_r == HUNT);
    assign len_en_s     = bus.DIN_VALID && (state_r == LENGTH);
    assign frm_en_s     = bus.DIN_VALID && (state_r == FRAME);
    assign last_frame_s = ((idx_r + LEN_W'(1)) == count_r);

    clb_cfg_shift #(.W(LEN_W)) u_len_shift (
        .clk  (K),
        .rst  (RST),
        .clr  (clr_s),
        .en   (len_en_s),
        .din  (bus.DIN),
        .word (len_word_s),
        .last (len_last_s)
    );

    clb_cfg_shift #(.W(CFG_W)) u_frm_shift (
        .clk  (K),
        .rst  (RST),
        .clr  (clr_s),
        .en   (frm_en_s),
        .din  (bus.DIN),
        .word (frm_word_s),
        .last (frm_last_s)
    );

    // Next-state and commit decision.
    always_comb begin
        state_nx_s    = state_r;
        commit_s      = 1'b0;
        commit_word_s = frm_word_s;
        case (state_r)
            HUNT: begin
                if (bus.DIN_VALID && ({hist_r, bus.DIN} == PREAMBLE)) begin
                    state_nx_s = LENGTH;
                end else begin
                    state_nx_s = HUNT;
                end
            end
            LENGTH: begin
                if (len_en_s && len_last_s) begin
                    if (len_word_s == {LEN_W{1'b0}}) begin
                        state_nx_s = DONE_S;
                    end else if (len_word_s > LEN_W'(NUM_CLB)) begin
                        state_nx_s = ERR_S;
                    end else begin
                        state_nx_s = FRAME;
                    end
                end else begin
                    state_nx_s = LENGTH;
                end
            end
            FRAME: begin
                if (frm_en_s && frm_last_s) begin
`ifdef CLB_CFG_PARITY_EN
                    state_nx_s = PAR;
`else
                    commit_s   = 1'b1;
                    state_nx_s = last_frame_s ? DONE_S : FRAME;
`endif
                end else begin
                    state_nx_s = FRAME;
                end
            end
`ifdef CLB_CFG_PARITY_EN
            PAR: begin
                if (bus.DIN_VALID) begin
                    if (even_parity_ok(hold_r, bus.DIN)) begin
                        commit_s      = 1'b1;
                        commit_word_s = hold_r;
                        state_nx_s    = last_frame_s ? DONE_S : FRAME;
                    end else begin
                        state_nx_s = ERR_S;
                    end
                end else begin
                    state_nx_s = PAR;
                end
            end
`endif
            DONE_S:  state_nx_s = DONE_S;
            ERR_S:   state_nx_s = ERR_S;
            default: state_nx_s = ERR_S;
        endcase
    end

`ifdef CLB_CFG_PARITY_EN
    assign busy_nx_s = (state_nx_s == LENGTH) || (state_nx_s == FRAME) || (state_nx_s == PAR);
`else
    assign busy_nx_s = (state_nx_s == LENGTH) || (state_nx_s == FRAME);
`endif

    // Control state: FSM, preamble history, frame count and frame index.
    always_ff @(posedge K) begin
        if (RST) begin
            state_r <= HUNT;
            hist_r  <= HIST_RST;
            count_r <= {LEN_W{1'b0}};
            idx_r   <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if ((state_r == HUNT) && bus.DIN_VALID) begin
                hist_r <= {hist_r[1:0], bus.DIN};
            end
            if (len_en_s && len_last_s) begin
                count_r <= len_word_s;
            end
            if (commit_s) begin
                idx_r <= idx_r + LEN_W'(1);
            end
        end
    end

`ifdef CLB_CFG_PARITY_EN
    // Completed frame is parked here while its parity bit is awaited.
    always_ff @(posedge K) begin
        if (RST) begin
            hold_r <= {CFG_W{1'b0}};
        end else if (frm_en_s && frm_last_s) begin
            hold_r <= frm_word_s;
        end
    end
`endif

    // Registered outputs; DATA/ADDR hold between strobes, DONE/ERR are sticky.
    always_ff @(posedge K) begin
        if (RST) begin
            cfg_data_r <= {CFG_W{1'b0}};
            cfg_addr_r <= {ADDR_W{1'b0}};
            cfg_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            cfg_we_r <= commit_s;
            if (commit_s) begin
                cfg_data_r <= commit_word_s;
                cfg_addr_r <= idx_r[ADDR_W-1:0];
            end
            busy_r <= busy_nx_s;
            done_r <= done_r | (state_r == DONE_S);
            err_r  <= err_r | (state_r == ERR_S);
        end
    end

    assign bus.CFG_DATA = cfg_data_r;
    assign bus.CFG_ADDR = cfg_addr_r;
    assign bus.CFG_WE   = cfg_we_r;
    assign bus.BUSY     = busy_r;
    assign bus.DONE     = done_r;
    assign bus.ERR      = err_r;
endmodule
